// File: rtl/nor_flash_emulator_pkg.sv
// Shared definitions for the NOR flash emulator: command codes, unlock addresses,
// command FSM states and the status toggle bit.
package nor_flash_emulator_pkg;

  localparam logic [7:0] CmdUnlock1   = 8'hAA;
  localparam logic [7:0] CmdUnlock2   = 8'h55;
  localparam logic [7:0] CmdProgram   = 8'hA0;
  localparam logic [7:0] CmdErase     = 8'h80;
  localparam logic [7:0] CmdChipErase = 8'h10;
  localparam logic [7:0] CmdReset     = 8'hF0;

  localparam logic [11:0] AddrUnlock1 = 12'h555;
  localparam logic [11:0] AddrUnlock2 = 12'h2AA;

  localparam int unsigned StatusBit = 6;

  typedef enum logic [3:0] {
    StIdle,
    StUnlk1,
    StUnlk2,
    StProgData,
    StErs1,
    StErs2,
    StErs3,
    StBusyProg,
    StBusyErase
  } cmd_state_e;

  function automatic logic is_busy(cmd_state_e s);
    return (s == StBusyProg) || (s == StBusyErase);
  endfunction

endpackage

// File: rtl/nor_flash_emulator_mem.sv
// Single-port synchronous word array with 1-clock read. Writes either clear bits
// (AND with write data, as a flash program does) or set the word to all ones.
module nor_flash_emulator_mem #(
  parameter int unsigned MEMBITS  = 10,
  parameter int unsigned DATABITS = 16
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                ones_i,
  input  logic [MEMBITS-1:0]  addr_i,
  input  logic [DATABITS-1:0] wdata_i,
  output logic [DATABITS-1:0] rdata_o
);

  logic [DATABITS-1:0] mem_q [2**MEMBITS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= ones_i ? '1 : (mem_q[addr_i] & wdata_i);
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/nor_flash_emulator.sv
// Device end of the parallel NOR bus: timed reads, AMD-style unlock/program/chip-erase
// command decoder, RY/BY# and status-toggle reads while busy.
module nor_flash_emulator
  import nor_flash_emulator_pkg::*;
#(
  parameter int unsigned ADDRBITS     = 26,
  parameter int unsigned DATABITS     = 16,
  parameter int unsigned MEMBITS      = 10,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned PROG_CYCLES  = 32,
  parameter int unsigned COUNTERBITS  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDRBITS-1:0] nor_addr_i,
  input  logic [DATABITS-1:0] nor_data_i,
  input  logic                nor_ce_i,
  input  logic                nor_we_i,
  input  logic                nor_oe_i,
  input  logic                nor_data_oe_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic                nor_data_oe_o,
  output logic                nor_ry_o,
  output logic                cmd_err_o,
  output logic                contention_o
);

  localparam logic [COUNTERBITS-1:0] RdLat     = COUNTERBITS'(READ_LATENCY);
  localparam logic [COUNTERBITS-1:0] ProgLast  = COUNTERBITS'(PROG_CYCLES - 1);
  localparam logic [COUNTERBITS-1:0] EraseLast = COUNTERBITS'(2**MEMBITS - 1);

  logic [ADDRBITS-1:0]    addr_q, addr_p_q;
  logic [DATABITS-1:0]    data_q;
  logic                   ce_q, we_q, oe_q, ce_p_q, we_p_q, conf_p_q, bad_q, bad_d;
  logic [11:0]            cap_addr_q;
  logic [DATABITS-1:0]    cap_data_q;
  logic [COUNTERBITS-1:0] rd_cnt_q, rd_cnt_d, busy_cnt_q, busy_cnt_d;
  logic                   tog_q, tog_d;
  cmd_state_e             state_q, state_d;
  logic [MEMBITS-1:0]     prog_addr_q, mem_addr;
  logic [DATABITS-1:0]    prog_data_q, mem_rdata, status, data_o_d;
  logic                   data_oe_d, cmd_err_d, fsm_err;
  logic                   rd_active, rd_fire, conflict, wr_evt, busy, mem_we, mem_ones;

  assign rd_active = !ce_q && !oe_q && we_q;
  assign conflict  = !ce_q && !oe_q && !we_q;
  // A write commits on the WE# rising edge unless OE# overlapped the low phase.
  assign wr_evt    = we_q && !we_p_q && !ce_p_q && !bad_q;
  assign bad_d     = we_q ? 1'b0 : (bad_q || conflict);
  assign busy      = is_busy(state_q);

  assign nor_ry_o     = !busy;
  assign contention_o = nor_data_oe_o && nor_data_oe_i;

  // Read timer: consecutive clocks with the read strobe held on one address.
  always_comb begin
    rd_cnt_d = '0;
    if (rd_active) begin
      if (addr_q != addr_p_q) begin
        rd_cnt_d = COUNTERBITS'(1);
      end else if (rd_cnt_q <= RdLat) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  assign rd_fire = rd_active && (rd_cnt_d == RdLat);

  always_comb begin
    status            = '0;
    status[StatusBit] = !tog_q;
    data_o_d          = nor_data_o;
    data_oe_d         = nor_data_oe_o;
    tog_d             = busy ? tog_q : 1'b0;
    if (rd_fire) begin
      data_oe_d = 1'b1;
      data_o_d  = busy ? status : mem_rdata;
      if (busy) begin
        tog_d = !tog_q;
      end
    end else if (!rd_active) begin
      data_oe_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = '0;
    fsm_err    = 1'b0;
    if (busy) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
      if (busy_cnt_q == ((state_q == StBusyProg) ? ProgLast : EraseLast)) begin
        state_d    = StIdle;
        busy_cnt_d = '0;
      end
    end else if (wr_evt) begin
      state_d = StIdle;
      unique case (state_q)
        StIdle: begin
          if (cap_addr_q == AddrUnlock1 && cap_data_q[7:0] == CmdUnlock1) state_d = StUnlk1;
        end
        StUnlk1: begin
          if (cap_addr_q == AddrUnlock2 && cap_data_q[7:0] == CmdUnlock2) state_d = StUnlk2;
        end
        StUnlk2: begin
          if (cap_addr_q == AddrUnlock1 && cap_data_q[7:0] == CmdProgram) begin
            state_d = StProgData;
          end else if (cap_addr_q == AddrUnlock1 && cap_data_q[7:0] == CmdErase) begin
            state_d = StErs1;
          end
        end
        StProgData: state_d = StBusyProg;
        StErs1: begin
          if (cap_addr_q == AddrUnlock1 && cap_data_q[7:0] == CmdUnlock1) state_d = StErs2;
        end
        StErs2: begin
          if (cap_addr_q == AddrUnlock2 && cap_data_q[7:0] == CmdUnlock2) state_d = StErs3;
        end
        StErs3: begin
          if (cap_addr_q == AddrUnlock1 && cap_data_q[7:0] == CmdChipErase) begin
            state_d = StBusyErase;
          end
        end
        default: state_d = StIdle;
      endcase
      fsm_err = (state_d == StIdle) && (cap_data_q[7:0] != CmdReset);
    end
  end

  assign cmd_err_d = fsm_err || (conflict && !conf_p_q);

  // Idle reads index the array from the raw pins so data lines up with addr_q.
  assign mem_we   = ((state_q == StBusyProg) && (busy_cnt_q == '0)) || (state_q == StBusyErase);
  assign mem_ones = (state_q == StBusyErase);
  assign mem_addr = (state_q == StBusyErase) ? busy_cnt_q[MEMBITS-1:0] :
                    (state_q == StBusyProg)  ? prog_addr_q : nor_addr_i[MEMBITS-1:0];

  nor_flash_emulator_mem #(
    .MEMBITS (MEMBITS),
    .DATABITS(DATABITS)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .ones_i (mem_ones),
    .addr_i (mem_addr),
    .wdata_i(prog_data_q),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q        <= '0;
      addr_p_q      <= '0;
      data_q        <= '0;
      ce_q          <= 1'b1;
      we_q          <= 1'b1;
      oe_q          <= 1'b1;
      ce_p_q        <= 1'b1;
      we_p_q        <= 1'b1;
      conf_p_q      <= 1'b0;
      bad_q         <= 1'b0;
      cap_addr_q    <= '0;
      cap_data_q    <= '0;
      rd_cnt_q      <= '0;
      busy_cnt_q    <= '0;
      tog_q         <= 1'b0;
      state_q       <= StIdle;
      prog_addr_q   <= '0;
      prog_data_q   <= '0;
      nor_data_o    <= '0;
      nor_data_oe_o <= 1'b0;
      cmd_err_o     <= 1'b0;
    end else begin
      addr_q        <= nor_addr_i;
      addr_p_q      <= addr_q;
      data_q        <= nor_data_i;
      ce_q          <= nor_ce_i;
      we_q          <= nor_we_i;
      oe_q          <= nor_oe_i;
      ce_p_q        <= ce_q;
      we_p_q        <= we_q;
      conf_p_q      <= conflict;
      bad_q         <= bad_d;
      if (!we_q && !ce_q) begin
        cap_addr_q <= addr_q[11:0];
        cap_data_q <= data_q;
      end
      if (state_q == StProgData && wr_evt) begin
        prog_addr_q <= cap_addr_q[MEMBITS-1:0];
        prog_data_q <= cap_data_q;
      end
      rd_cnt_q      <= rd_cnt_d;
      busy_cnt_q    <= busy_cnt_d;
      tog_q         <= tog_d;
      state_q       <= state_d;
      nor_data_o    <= data_o_d;
      nor_data_oe_o <= data_oe_d;
      cmd_err_o     <= cmd_err_d;
    end
  end

endmodule
